// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   Single-outstanding APB requester. Accepts one command through a
//   valid/ready handshake, runs the APB SETUP/ACCESS phases, and returns the
//   completer's response through a second valid/ready handshake.
//
//   Optional feature macro: APB_MASTER_TIMEOUT_EN
//     When defined, an ACCESS phase that has not seen PREADY by its
//     timeout_cycles-th cycle is aborted. The response then reports
//     rsp_error=1 and rsp_timeout=1. When undefined, ACCESS waits forever
//     and rsp_timeout is tied to 0.
//
// Parameters
//   addr_width     : APB address width
//   data_width     : APB data width
//   timeout_cycles : ACCESS cycles allowed before abort (1..255)
//
// Ports
//   PCLK, PRESET          : clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/wdata  : command payload, captured on acceptance
//   PSELx, PENABLE,
//   PWRITE, PADDR, PWDATA : APB requester outputs
//   PREADY, PRDATA,
//   PSLVERR               : APB completer response
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_error,
//   rsp_timeout           : response payload, held stable while rsp_valid=1
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int addr_width     = 4,
    parameter int data_width     = 128,
    parameter int timeout_cycles = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // command request
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [data_width-1:0] cmd_wdata,
    // APB requester
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [addr_width-1:0] PADDR,
    output logic [data_width-1:0] PWDATA,
    // APB completer response
    input  logic                  PREADY,
    input  logic [data_width-1:0] PRDATA,
    input  logic                  PSLVERR,
    // response
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout
);

    // Elaboration-time range check on the timeout length.
    if (timeout_cycles < 1 || timeout_cycles > 255) begin : g_bad_timeout
        $error("apb_master: timeout_cycles must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_done;

    logic                  r_pwrite;
    logic [addr_width-1:0] r_paddr;
    logic [data_width-1:0] r_pwdata;
    logic [data_width-1:0] r_rsp_rdata;
    logic                  r_rsp_error;

`ifdef APB_MASTER_TIMEOUT_EN
    // Index of the last permitted ACCESS cycle; the counter reads 0 in the
    // first ACCESS cycle, so the timeout_cycles-th cycle sees this value.
    localparam logic [7:0] TO_LAST = 8'(timeout_cycles - 1);

    logic [7:0]            r_tcnt;
    logic                  w_abort;
    logic                  r_rsp_timeout;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        w_abort  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                // Completion wins over the timeout in the same cycle.
                if (PREADY) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (r_tcnt == TO_LAST) begin
                    w_abort = 1'b1;
                    w_next  = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------- datapath regs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            // Address/data/direction change only on command acceptance.
            if (w_accept) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
            end
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                r_rsp_error <= PSLVERR;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (w_abort) begin
                r_rsp_rdata <= '0;
                r_rsp_error <= 1'b1;
            end
`endif
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_tcnt        <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept)
                r_tcnt <= '0;
            else if (r_state == ACCESS && !PREADY)
                r_tcnt <= r_tcnt + 8'd1;

            if (w_done)
                r_rsp_timeout <= 1'b0;
            else if (w_abort)
                r_rsp_timeout <= 1'b1;
        end
    end
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    // ------------------------------------------------------------ outputs
    // Strobes decode straight from the state register so reset drops them
    // in the same instant it forces IDLE.
    assign cmd_ready = (r_state == IDLE);
    assign PSELx     = (r_state == SETUP) || (r_state == ACCESS);
    assign PENABLE   = (r_state == ACCESS);
    assign rsp_valid = (r_state == RESP);
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//   Directed bench for apb_master with default parameters. Inputs are driven
//   and outputs checked on the falling edge of PCLK.
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam int AW = 4;
    localparam int DW = 128;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error, rsp_timeout;

    int npass = 0;
    int ntot  = 0;

    localparam logic [DW-1:0] WD_A5  = {16{8'hA5}};
    localparam logic [DW-1:0] RD_PAT = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] JUNK   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    apb_master #(.addr_width(AW), .data_width(DW), .timeout_cycles(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    // Every output at its reset value.
    task automatic chk_reset_vals(input string tag);
        chk({tag, ".psel"},   DW'(PSELx),       '0);
        chk({tag, ".pen"},    DW'(PENABLE),     '0);
        chk({tag, ".pwrite"}, DW'(PWRITE),      '0);
        chk({tag, ".paddr"},  DW'(PADDR),       '0);
        chk({tag, ".pwdata"}, PWDATA,           '0);
        chk({tag, ".rvalid"}, DW'(rsp_valid),   '0);
        chk({tag, ".rdata"},  rsp_rdata,        '0);
        chk({tag, ".rerr"},   DW'(rsp_error),   '0);
        chk({tag, ".rto"},    DW'(rsp_timeout), '0);
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        rsp_ready = 1'b1;

        // ---- reset state
        step(); step();
        chk_reset_vals("rst");
        PRESET = 1'b0;
        step();
        chk("rst.cmd_ready", DW'(cmd_ready), 1);

        // ---- write addr 3, zero wait states: SETUP, ACCESS, RESP, IDLE
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = WD_A5;
        PREADY = 1'b1; PRDATA = JUNK;
        step();                                   // SETUP
        cmd_valid = 1'b0;
        chk("wr.setup.psel",  DW'(PSELx),   1);
        chk("wr.setup.pen",   DW'(PENABLE), 0);
        chk("wr.setup.paddr", DW'(PADDR),   3);
        chk("wr.setup.pwr",   DW'(PWRITE),  1);
        chk("wr.setup.crdy",  DW'(cmd_ready), 0);
        step();                                   // ACCESS
        chk("wr.acc.psel",   DW'(PSELx),   1);
        chk("wr.acc.pen",    DW'(PENABLE), 1);
        chk("wr.acc.paddr",  DW'(PADDR),   3);
        chk("wr.acc.pwdata", PWDATA,       WD_A5);
        step();                                   // RESP
        chk("wr.rsp.valid", DW'(rsp_valid), 1);
        chk("wr.rsp.psel",  DW'(PSELx),     0);
        chk("wr.rsp.pen",   DW'(PENABLE),   0);
        chk("wr.rsp.err",   DW'(rsp_error), 0);
        chk("wr.rsp.rdata", rsp_rdata,      '0);
        step();                                   // IDLE
        chk("wr.idle.crdy",  DW'(cmd_ready), 1);
        chk("wr.idle.valid", DW'(rsp_valid), 0);
        chk("wr.idle.paddr", DW'(PADDR),     3);
        chk("wr.idle.pwdata", PWDATA,        WD_A5);

        // ---- read addr F, three wait states then PREADY
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hF; cmd_wdata = JUNK;
        PREADY = 1'b0;
        step();                                   // SETUP
        cmd_valid = 1'b0;
        chk("rd.setup.pwr", DW'(PWRITE), 0);
        for (int i = 0; i < 4; i++) begin
            step();                               // ACCESS i+1
            chk($sformatf("rd.acc%0d.pen", i),   DW'(PENABLE), 1);
            chk($sformatf("rd.acc%0d.paddr", i), DW'(PADDR),   4'hF);
            if (i == 3) begin PREADY = 1'b1; PRDATA = RD_PAT; end
        end
        step();                                   // RESP
        chk("rd.rsp.valid", DW'(rsp_valid),   1);
        chk("rd.rsp.rdata", rsp_rdata,        RD_PAT);
        chk("rd.rsp.err",   DW'(rsp_error),   0);
        chk("rd.rsp.to",    DW'(rsp_timeout), 0);
        step();                                   // IDLE

        // ---- read with PSLVERR at completion
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = JUNK;
        step();
        cmd_valid = 1'b0;
        step(); step();                           // ACCESS, RESP
        chk("err.rsp.valid", DW'(rsp_valid),   1);
        chk("err.rsp.err",   DW'(rsp_error),   1);
        chk("err.rsp.to",    DW'(rsp_timeout), 0);
        chk("err.rsp.rdata", rsp_rdata,        JUNK);
        PSLVERR = 1'b0;
        step();

        // ---- response back-pressure with cmd_valid held high
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h7; cmd_wdata = WD_A5;
        PREADY = 1'b1; rsp_ready = 1'b0;
        step();                                   // SETUP
        cmd_write = 1'b0; cmd_addr = 4'h9; cmd_wdata = JUNK;  // must be ignored
        step(); step();                           // ACCESS, RESP
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.valid", i), DW'(rsp_valid), 1);
            chk($sformatf("bp%0d.crdy", i),  DW'(cmd_ready), 0);
            chk($sformatf("bp%0d.rdata", i), rsp_rdata,      '0);
            chk($sformatf("bp%0d.err", i),   DW'(rsp_error), 0);
            chk($sformatf("bp%0d.paddr", i), DW'(PADDR),     7);
            chk($sformatf("bp%0d.psel", i),  DW'(PSELx),     0);
            if (i == 4) rsp_ready = 1'b1;
            step();
        end
        chk("bp.idle.crdy",  DW'(cmd_ready), 1);
        chk("bp.idle.valid", DW'(rsp_valid), 0);
        step();                                   // accepted -> SETUP
        cmd_valid = 1'b0;
        chk("bp.next.psel",  DW'(PSELx),  1);
        chk("bp.next.paddr", DW'(PADDR),  9);
        chk("bp.next.pwr",   DW'(PWRITE), 0);
        step(); step(); step();                   // ACCESS, RESP, IDLE
        chk("bp.done.crdy", DW'(cmd_ready), 1);

`ifdef APB_MASTER_TIMEOUT_EN
        // ---- timeout: PREADY never arrives
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        PREADY = 1'b0; PRDATA = JUNK;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            step();
            chk($sformatf("to.acc%0d.pen", i), DW'(PENABLE), 1);
        end
        step();
        chk("to.rsp.valid", DW'(rsp_valid),   1);
        chk("to.rsp.psel",  DW'(PSELx),       0);
        chk("to.rsp.err",   DW'(rsp_error),   1);
        chk("to.rsp.to",    DW'(rsp_timeout), 1);
        chk("to.rsp.rdata", rsp_rdata,        '0);
        step();

        // ---- PREADY exactly in the last allowed cycle completes normally
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        PREADY = 1'b0; PRDATA = RD_PAT;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            step();
            if (i == TO - 1) PREADY = 1'b1;
        end
        step();
        chk("tol.rsp.valid", DW'(rsp_valid),   1);
        chk("tol.rsp.err",   DW'(rsp_error),   0);
        chk("tol.rsp.to",    DW'(rsp_timeout), 0);
        chk("tol.rsp.rdata", rsp_rdata,        RD_PAT);
        step();
`else
        // ---- without the timeout, ACCESS waits well past TO cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        PREADY = 1'b0; PRDATA = RD_PAT;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < TO + 4; i++) step();
        chk("wait.acc.pen",   DW'(PENABLE),   1);
        chk("wait.acc.valid", DW'(rsp_valid), 0);
        PREADY = 1'b1;
        step();
        chk("wait.rsp.valid", DW'(rsp_valid),   1);
        chk("wait.rsp.to",    DW'(rsp_timeout), 0);
        chk("wait.rsp.rdata", rsp_rdata,        RD_PAT);
        step();
`endif

        // ---- reset in the second ACCESS cycle drops the transfer
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = WD_A5;
        PREADY = 1'b0;
        step();                                   // SETUP
        cmd_valid = 1'b0;
        step();                                   // ACCESS 1
        step();                                   // ACCESS 2
        chk("mid.acc2.pen", DW'(PENABLE), 1);
        PRESET = 1'b1;
        #1;
        chk_reset_vals("mid");
        step();
        PRESET = 1'b0; PREADY = 1'b1;
        step();
        chk("mid.post.crdy",  DW'(cmd_ready), 1);
        chk("mid.post.valid", DW'(rsp_valid), 0);
        step();
        chk("mid.post2.valid", DW'(rsp_valid), 0);
        chk("mid.post2.psel",  DW'(PSELx),     0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter addr_width, default 4, APB address width.
REQ-002 SHALL have parameter data_width, default 128, APB data width.
REQ-003 SHALL have parameter timeout_cycles, default 16, maximum ACCESS cycles before abort (range 1..255).
REQ-004 SHALL have the port PCLK, input, 1, the single clock; all logic on the rising edge.
REQ-005 SHALL have the port PRESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have the ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1), cmd_addr (in, addr_width) and cmd_wdata (in, data_width), which form the command request handshake.
REQ-007 SHALL have the ports PSELx, PENABLE and PWRITE (out, 1 each), PADDR (out, addr_width) and PWDATA (out, data_width), which form the APB requester outputs.
REQ-008 SHALL have the ports PREADY (in, 1), PRDATA (in, data_width) and PSLVERR (in, 1), the completer response; these connect to m_ready, m_rdata and m_error of the downstream APB top.
REQ-009 SHALL have the ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, data_width), rsp_error (out, 1) and rsp_timeout (out, 1), which form the response handshake.

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-011 SHALL assert cmd_ready only in IDLE; cmd_valid&&cmd_ready SHALL register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
REQ-012 In SETUP, SHALL drive PSELx=1 and PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-013 In ACCESS, SHALL drive PSELx=1 and PENABLE=1, holding PADDR, PWDATA and PWRITE stable until PREADY is sampled high.
REQ-014 When PREADY=1 is sampled in ACCESS, SHALL capture rsp_rdata=PRDATA for a read (all-zero for a write) and rsp_error=PSLVERR, set rsp_timeout=0, and go to RESP.
REQ-015 In RESP, SHALL hold PSELx=0, PENABLE=0 and rsp_valid=1 with stable rsp_* until rsp_ready=1, then go to IDLE.
REQ-016 Throughput SHALL be at most one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP) with zero wait states and rsp_ready tied high.
REQ-017 SHALL keep PADDR, PWDATA and PWRITE holding their last values outside SETUP/ACCESS; they SHALL change only on command acceptance.
REQ-018 SHALL never assert PENABLE without PSELx, and SHALL never assert PSELx outside SETUP/ACCESS.
REQ-019 SHALL ignore cmd_valid outside IDLE; commands SHALL NOT be queued.

Reset
REQ-020 PRESET=1 SHALL immediately force IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, timeout counter=0; cmd_ready=1 after release.
REQ-021 Reset during SETUP, ACCESS or RESP SHALL drop the in-flight transfer with no response produced.

Configuration
REQ-022 With macro APB_MASTER_TIMEOUT_EN defined, SHALL count ACCESS cycles; if PREADY is still 0 in the timeout_cycles-th ACCESS cycle, SHALL abort to RESP with rsp_error=1, rsp_timeout=1 and rsp_rdata=0, deasserting PSELx/PENABLE in the next cycle.
REQ-023 With APB_MASTER_TIMEOUT_EN defined, PREADY=1 in the timeout_cycles-th ACCESS cycle SHALL complete normally (REQ-014); completion takes priority over the timeout.
REQ-024 With APB_MASTER_TIMEOUT_EN defined, the counter SHALL clear on entry to SETUP.
REQ-025 Without APB_MASTER_TIMEOUT_EN, SHALL wait in ACCESS indefinitely and tie rsp_timeout to 0.

Verification
REQ-026 Write addr=4'h3, wdata=128'hA5..A5, PREADY=1 -> one SETUP cycle then one ACCESS cycle with PADDR=3 and PWRITE=1; rsp_valid with rsp_error=0 and rsp_rdata=0.
REQ-027 Read addr=4'hF, PREADY low for 3 ACCESS cycles then high with PRDATA=128'h0123..CDEF -> PADDR stable for 4 ACCESS cycles; rsp_rdata=128'h0123..CDEF.
REQ-028 Read with PSLVERR=1 at completion -> rsp_error=1, rsp_timeout=0.
REQ-029 rsp_ready=0 for 5 cycles after a response, cmd_valid=1 throughout -> rsp_* stable and cmd_ready=0 until the handshake; next command accepted the cycle after returning to IDLE.
REQ-030 APB_MASTER_TIMEOUT_EN defined, timeout_cycles=16, PREADY held 0 -> abort after 16 ACCESS cycles with rsp_error=1 and rsp_timeout=1; repeat with PREADY=1 on cycle 16 -> normal completion.
REQ-031 PRESET pulsed in the second ACCESS cycle -> PSELx and PENABLE drop immediately, no rsp_valid, all outputs at REQ-020 values.
